// File: rtl/semaforo_pkg.sv
// Shared definitions for the semaforo traffic-light controller.
// Holds the phase encoding, lamp codes, default timing values and the
// lamp decode helper used by the phase scheduler.
package semaforo_pkg;

    // Phase encoding; the value is also exported on the phase debug port.
    typedef enum logic [2:0] {
        A_GREEN   = 3'd0,
        A_YELLOW  = 3'd1,
        ALLRED_AB = 3'd2,
        B_GREEN   = 3'd3,
        B_YELLOW  = 3'd4,
        ALLRED_BA = 3'd5,
        FLASH     = 3'd6
    } state_t;

    // Lamp codes, bit order {red, yellow, green}.
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    // Default timing, in ticks.
    localparam int DEF_GREEN_MIN = 8;
    localparam int DEF_GREEN_MAX = 20;
    localparam int DEF_YELLOW_T  = 3;
    localparam int DEF_ALLRED_T  = 1;
    localparam int DEF_WALK_T    = 5;
    localparam int DEF_CNT_W     = 5;

    // Lamp pattern {light_a, light_b} for a phase. lit selects the on half
    // of the flashing cycle; it is ignored outside FLASH.
    function automatic logic [5:0] lamps_for(input state_t s, input logic lit);
        logic [5:0] l;
        l = {LAMP_RED, LAMP_RED};
        case (s)
            A_GREEN:  l = {LAMP_GRN, LAMP_RED};
            A_YELLOW: l = {LAMP_YEL, LAMP_RED};
            B_GREEN:  l = {LAMP_RED, LAMP_GRN};
            B_YELLOW: l = {LAMP_RED, LAMP_YEL};
            FLASH:    l = lit ? {LAMP_YEL, LAMP_RED} : {LAMP_OFF, LAMP_OFF};
            default:  l = {LAMP_RED, LAMP_RED};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/semaforo_tick_timer.sv
// Phase timer: counts tick strobes, saturates at all-ones, and clears
// synchronously. clear has priority over counting so a state change always
// starts the new phase at zero.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   tick       count enable strobe
//   clear      synchronous clear
//   count      current tick count
module semaforo_tick_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (tick && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/semaforo_phase_scheduler.sv
// Phase sequencer for the two-road intersection. Runs the light state
// machine, arbitrates green time between main road A and side road B from
// the car_b sensor and latched pedestrian requests, and drives registered
// lamp and walk outputs. All timing is counted in tick strobes.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   tick              single-cycle timing strobe
//   car_b             side-road vehicle sensor (level)
//   ped_a, ped_b      pedestrian requests (pulse or level), latched
//   night_mode        flashing-mode request, honoured at all-red only
//   light_a, light_b  lamps {red,yellow,green}
//   walk_a, walk_b    pedestrian walk signals
//   phase             current state encoding (debug)
module semaforo_phase_scheduler
    import semaforo_pkg::*;
#(
    parameter int GREEN_MIN = DEF_GREEN_MIN,
    parameter int GREEN_MAX = DEF_GREEN_MAX,
    parameter int YELLOW_T  = DEF_YELLOW_T,
    parameter int ALLRED_T  = DEF_ALLRED_T,
    parameter int WALK_T    = DEF_WALK_T,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       car_b,
    input  logic       ped_a,
    input  logic       ped_b,
    input  logic       night_mode,
    output logic [2:0] light_a,
    output logic [2:0] light_b,
    output logic       walk_a,
    output logic       walk_b,
    output logic [2:0] phase
);

    // Thresholds compared against t = timer+1, one bit wider than the timer
    // so a saturated timer cannot wrap t back to zero.
    localparam logic [CNT_W:0]   T_GMIN = (CNT_W+1)'(GREEN_MIN);
    localparam logic [CNT_W:0]   T_GMAX = (CNT_W+1)'(GREEN_MAX);
    localparam logic [CNT_W:0]   T_YEL  = (CNT_W+1)'(YELLOW_T);
    localparam logic [CNT_W:0]   T_AR   = (CNT_W+1)'(ALLRED_T);
    localparam logic [CNT_W-1:0] T_WALK = CNT_W'(WALK_T);

    state_t           state, state_nx;
    logic [CNT_W-1:0] count, count_nx;
    logic [CNT_W:0]   t;
    logic             change;
    logic             enter_a, enter_b;
    logic             latch_a, latch_b, latch_a_nx, latch_b_nx;
    logic             walk_en_a, walk_en_b, walk_en_a_nx, walk_en_b_nx;
    logic             flash_on, flash_nx;

    semaforo_tick_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .clear (change),
        .count (count)
    );

    assign t = {1'b0, count} + (CNT_W+1)'(1);

    // Next-state logic; transitions only happen on tick cycles.
    always_comb begin
        state_nx = state;
        if (tick) begin
            case (state)
                A_GREEN:   if (t >= T_GMIN && (car_b || latch_b)) state_nx = A_YELLOW;
                A_YELLOW:  if (t == T_YEL) state_nx = ALLRED_AB;
                ALLRED_AB: if (t == T_AR) state_nx = night_mode ? FLASH : B_GREEN;
                B_GREEN:   if (t == T_GMAX || (t >= T_GMIN && !car_b)) state_nx = B_YELLOW;
                B_YELLOW:  if (t == T_YEL) state_nx = ALLRED_BA;
                ALLRED_BA: if (t == T_AR) state_nx = night_mode ? FLASH : A_GREEN;
                FLASH:     if (!night_mode) state_nx = ALLRED_BA;
                default:   state_nx = ALLRED_BA;
            endcase
        end
    end

    // Side-band next values. The timer value the register will hold after
    // this edge is needed here so walk can be decoded from next state.
    always_comb begin
        change  = (state_nx != state);
        enter_a = change && (state_nx == A_GREEN);
        enter_b = change && (state_nx == B_GREEN);

        count_nx = count;
        if (change) begin
            count_nx = '0;
        end else if (tick && (count != '1)) begin
            count_nx = count + CNT_W'(1);
        end

        // Walk eligibility is captured from the latch as it stood on entry.
        walk_en_a_nx = enter_a ? latch_a : walk_en_a;
        walk_en_b_nx = enter_b ? latch_b : walk_en_b;

        // A new request in the clearing cycle wins over the clear.
        latch_a_nx = ped_a ? 1'b1 : (enter_a ? 1'b0 : latch_a);
        latch_b_nx = ped_b ? 1'b1 : (enter_b ? 1'b0 : latch_b);

        // Flashing starts lit and toggles on every tick spent in FLASH.
        flash_nx = flash_on;
        if (change && (state_nx == FLASH)) begin
            flash_nx = 1'b1;
        end else if ((state == FLASH) && tick) begin
            flash_nx = ~flash_on;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ALLRED_BA;
            latch_a   <= 1'b0;
            latch_b   <= 1'b0;
            walk_en_a <= 1'b0;
            walk_en_b <= 1'b0;
            flash_on  <= 1'b0;
            light_a   <= LAMP_RED;
            light_b   <= LAMP_RED;
            walk_a    <= 1'b0;
            walk_b    <= 1'b0;
        end else begin
            state     <= state_nx;
            latch_a   <= latch_a_nx;
            latch_b   <= latch_b_nx;
            walk_en_a <= walk_en_a_nx;
            walk_en_b <= walk_en_b_nx;
            flash_on  <= flash_nx;
            {light_a, light_b} <= lamps_for(state_nx, flash_nx);
            walk_a    <= (state_nx == A_GREEN) && walk_en_a_nx && (count_nx < T_WALK);
            walk_b    <= (state_nx == B_GREEN) && walk_en_b_nx && (count_nx < T_WALK);
        end
    end

    assign phase = state;

endmodule
